// File: rtl/watch_pkg.sv
// Shared constants and types for the watch mode sequencer.
package watch_pkg;

  // Mode numbering; the home mode is the one the watch falls back to.
  localparam int MODE_CLOCK     = 0;
  localparam int MODE_STOPWATCH = 1;
  localparam int MODE_TIMER     = 2;
  localparam int MODE_HOME      = MODE_CLOCK;

  // Mode-key FSM: waiting, key held (short or long not yet decided), long press consumed.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_DONE
  } mode_state_e;

endpackage

// File: rtl/watch_mode_ctrl_if.sv
// User-input / display bundle between the watch top level and the mode sequencer.
interface watch_mode_ctrl_if #(
  parameter int NUM_MODES = 4,
  parameter int NUM_KEYS  = 3,
  parameter int DIGITS    = 3,
  parameter int DIG_W     = 8,
  parameter int BLANK_W   = 4
) ();

  localparam int MW = $clog2(NUM_MODES);

  logic                              mode_key;
  logic [NUM_KEYS-1:0]               keys_raw;
  logic [NUM_MODES*DIGITS*DIG_W-1:0] mode_data;
  logic [NUM_MODES*BLANK_W-1:0]      mode_blank;
  logic [MW-1:0]                     mode;
  logic [NUM_MODES-1:0]              mode_led;
  logic [NUM_MODES*NUM_KEYS-1:0]     key_pulse;
  logic [NUM_MODES*NUM_KEYS-1:0]     key_held;
  logic [DIGITS*DIG_W-1:0]           disp_data;
  logic [BLANK_W-1:0]                disp_blank;

  // Master drives buttons and per-mode display content; slave is the sequencer.
  modport master (
    output mode_key, keys_raw, mode_data, mode_blank,
    input  mode, mode_led, key_pulse, key_held, disp_data, disp_blank
  );

  modport slave (
    input  mode_key, keys_raw, mode_data, mode_blank,
    output mode, mode_led, key_pulse, key_held, disp_data, disp_blank
  );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Accept a new level only after the synced input has disagreed for DEBOUNCE_CYC cycles in a row.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Mode sequencer and button front end: debounces keys, steps modes, routes keys, muxes display.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int NUM_KEYS     = 3,
  parameter int DIGITS       = 3,
  parameter int DIG_W        = 8,
  parameter int BLANK_W      = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 50000000,
  parameter int TIMEOUT_CYC  = 0
) (
  input logic              clk,
  input logic              reset,
  watch_mode_ctrl_if.slave bus
);

  localparam int MW     = $clog2(NUM_MODES);
  localparam int KW     = NUM_MODES * NUM_KEYS;
  localparam int DW     = DIGITS * DIG_W;
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  // Index 0 is the mode key, indices 1..NUM_KEYS are the function keys.
  logic [NUM_KEYS:0] raw_vec, lvl_vec, prs_vec;
  assign raw_vec = {bus.keys_raw, bus.mode_key};

  for (genvar i = 0; i <= NUM_KEYS; i++) begin : g_deb
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_vec[i]),
      .level(lvl_vec[i]),
      .press(prs_vec[i])
    );
  end

  logic                mode_level, mode_press, any_press;
  logic [NUM_KEYS-1:0] fn_level, fn_press;
  assign mode_level = lvl_vec[0];
  assign mode_press = prs_vec[0];
  assign fn_level   = lvl_vec[NUM_KEYS:1];
  assign fn_press   = prs_vec[NUM_KEYS:1];
  assign any_press  = |prs_vec;

  mode_state_e         state, state_next;
  logic [HOLD_W-1:0]   hold_cnt, hold_next;
  logic [IDLE_W-1:0]   idle_cnt, idle_next;
  logic [MW-1:0]       mode, mode_next;
  logic                fsm_upd;
  logic [NUM_MODES-1:0] led_q, led_next;
  logic [KW-1:0]       pulse_q, pulse_next, held_q, held_next;
  logic [DW-1:0]       disp_q, disp_next;
  logic [BLANK_W-1:0]  blank_q, blank_next;

  // State register: FSM, counters, mode and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      idle_cnt <= '0;
      mode     <= MW'(MODE_HOME);
      led_q    <= NUM_MODES'(1);
      pulse_q  <= '0;
      held_q   <= '0;
      disp_q   <= '0;
      blank_q  <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      idle_cnt <= idle_next;
      mode     <= mode_next;
      led_q    <= led_next;
      pulse_q  <= pulse_next;
      held_q   <= held_next;
      disp_q   <= disp_next;
      blank_q  <= blank_next;
    end
  end

  // Next-state: short press advances the mode, long press returns home, idle timeout returns home.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    idle_next  = idle_cnt;
    mode_next  = mode;
    fsm_upd    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode_press) begin
          state_next = ST_PRESSED;
          hold_next  = '0;
        end
      end
      ST_PRESSED: begin
        if (!mode_level) begin
          mode_next  = (mode == MW'(NUM_MODES - 1)) ? '0 : mode + 1'b1;
          state_next = ST_IDLE;
          fsm_upd    = 1'b1;
        end else begin
          if (hold_cnt != HOLD_W'(LONG_CYC)) hold_next = hold_cnt + 1'b1;
          if (hold_cnt == HOLD_W'(LONG_CYC - 1)) begin
            mode_next  = MW'(MODE_HOME);
            state_next = ST_LONG_DONE;
            fsm_upd    = 1'b1;
          end
        end
      end
      ST_LONG_DONE: begin
        if (!mode_level) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (TIMEOUT_CYC > 0) begin
      if (any_press) begin
        idle_next = '0;
      end else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) begin
        idle_next = idle_cnt + 1'b1;
      end
      if (idle_cnt == IDLE_W'(TIMEOUT_CYC) && mode != MW'(MODE_HOME) &&
          state == ST_IDLE && !fsm_upd) begin
        mode_next = MW'(MODE_HOME);
        idle_next = '0;
      end
    end
  end

  // Outputs: keys decoded with the pre-update mode, held levels cleared on a mode change.
  always_comb begin
    led_next   = '0;
    pulse_next = '0;
    held_next  = '0;
    disp_next  = '0;
    blank_next = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      led_next[m] = (mode_next == MW'(m));
      if (mode == MW'(m)) begin
        pulse_next[m*NUM_KEYS +: NUM_KEYS] = fn_press;
        if (mode_next == mode) held_next[m*NUM_KEYS +: NUM_KEYS] = fn_level;
        disp_next  = bus.mode_data[m*DW +: DW];
        blank_next = bus.mode_blank[m*BLANK_W +: BLANK_W];
      end
    end
  end

  assign bus.mode       = mode;
  assign bus.mode_led   = led_q;
  assign bus.key_pulse  = pulse_q;
  assign bus.key_held   = held_q;
  assign bus.disp_data  = disp_q;
  assign bus.disp_blank = blank_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl with short debounce, long-press and timeout constants.
module tb_watch_mode_ctrl;

  localparam int NUM_MODES = 4;
  localparam int NUM_KEYS  = 3;
  localparam int DIGITS    = 3;
  localparam int DIG_W     = 8;
  localparam int BLANK_W   = 4;
  localparam int MW        = 2;
  localparam int KW        = NUM_MODES * NUM_KEYS;
  localparam int DW        = DIGITS * DIG_W;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  watch_mode_ctrl_if #(
    .NUM_MODES(NUM_MODES), .NUM_KEYS(NUM_KEYS), .DIGITS(DIGITS),
    .DIG_W(DIG_W), .BLANK_W(BLANK_W)
  ) bus ();

  watch_mode_ctrl #(
    .NUM_MODES(NUM_MODES), .NUM_KEYS(NUM_KEYS), .DIGITS(DIGITS),
    .DIG_W(DIG_W), .BLANK_W(BLANK_W),
    .DEBOUNCE_CYC(4), .LONG_CYC(20), .TIMEOUT_CYC(50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Distinct per-mode display content: digits 0xm1,0xm2,0xm3 and blank mask m+5.
  function automatic logic [DW-1:0] exp_digits(input int m);
    return {8'(16*m + 1), 8'(16*m + 2), 8'(16*m + 3)};
  endfunction

  function automatic logic [BLANK_W-1:0] exp_blank(input int m);
    return 4'(m + 5);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press the mode key for 8 cycles; mode flips 15 edges after the press, display one edge later.
  task automatic short_press(input int from_m, input int to_m);
    bus.mode_key = 1'b1;
    tick(8);
    bus.mode_key = 1'b0;
    tick(6);
    checks++;
    if (bus.mode !== MW'(from_m)) begin
      errors++;
      $display("FAIL short_press_hold: mode=%0d expected %0d", bus.mode, from_m);
    end
    tick(1);
    checks++;
    if (bus.mode !== MW'(to_m)) begin
      errors++;
      $display("FAIL short_press_mode: mode=%0d expected %0d", bus.mode, to_m);
    end
    checks++;
    if (bus.mode_led !== 4'(1 << to_m)) begin
      errors++;
      $display("FAIL short_press_led: mode_led=%b expected %b", bus.mode_led, 4'(1 << to_m));
    end
    tick(1);
    checks++;
    if (bus.disp_data !== exp_digits(to_m) || bus.disp_blank !== exp_blank(to_m)) begin
      errors++;
      $display("FAIL short_press_disp: data=%h blank=%h expected %h %h",
               bus.disp_data, bus.disp_blank, exp_digits(to_m), exp_blank(to_m));
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.mode_key = 1'b0;
    bus.keys_raw = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      bus.mode_data[m*DW +: DW]          = exp_digits(m);
      bus.mode_blank[m*BLANK_W +: BLANK_W] = exp_blank(m);
    end
    tick(3);
    checks++;
    if (bus.mode !== 2'd0 || bus.mode_led !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mode: mode=%0d led=%b expected 0 0001", bus.mode, bus.mode_led);
    end
    checks++;
    if (bus.key_pulse !== '0 || bus.key_held !== '0) begin
      errors++;
      $display("FAIL reset_keys: pulse=%h held=%h expected 0 0", bus.key_pulse, bus.key_held);
    end
    checks++;
    if (bus.disp_data !== '0 || bus.disp_blank !== '0) begin
      errors++;
      $display("FAIL reset_disp: data=%h blank=%h expected 0 0", bus.disp_data, bus.disp_blank);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (bus.disp_data !== exp_digits(0) || bus.disp_blank !== exp_blank(0)) begin
      errors++;
      $display("FAIL reset_release_disp: data=%h expected %h", bus.disp_data, exp_digits(0));
    end
  endtask

  task automatic test_key_debounce();
    int pulses   = 0;
    int pulse_at = -1;
    int stray    = 0;
    for (int i = 0; i < 6; i++) begin
      bus.keys_raw[0] = (i % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (bus.key_pulse !== '0) stray++;
      end
    end
    bus.keys_raw[0] = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      if (bus.key_pulse[0] === 1'b1) begin
        pulses++;
        pulse_at = c;
      end
      if (bus.key_pulse[KW-1:1] !== '0) stray++;
    end
    checks++;
    if (pulses != 1 || pulse_at != 7) begin
      errors++;
      $display("FAIL debounce_pulse: count=%0d at=%0d expected 1 at 7", pulses, pulse_at);
    end
    checks++;
    if (bus.key_held !== 12'h001) begin
      errors++;
      $display("FAIL debounce_held: key_held=%h expected 001", bus.key_held);
    end
    bus.keys_raw[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      if (bus.key_pulse !== '0) stray++;
    end
    checks++;
    if (bus.key_held !== 12'h001) begin
      errors++;
      $display("FAIL debounce_held_release: key_held=%h expected 001", bus.key_held);
    end
    tick(1);
    checks++;
    if (bus.key_held !== '0) begin
      errors++;
      $display("FAIL debounce_release: key_held=%h expected 000", bus.key_held);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL debounce_stray: stray pulse cycles=%0d expected 0", stray);
    end
    tick(5);
  endtask

  task automatic test_mode_cycle();
    short_press(0, 1);
    tick(5);
    short_press(1, 2);
    tick(5);
    short_press(2, 3);
    tick(5);
    short_press(3, 0);
    tick(5);
  endtask

  task automatic test_long_press();
    short_press(0, 1);
    tick(5);
    short_press(1, 2);
    tick(5);
    bus.mode_key = 1'b1;
    tick(26);
    checks++;
    if (bus.mode !== 2'd2) begin
      errors++;
      $display("FAIL long_before: mode=%0d expected 2", bus.mode);
    end
    tick(1);
    checks++;
    if (bus.mode !== 2'd0 || bus.mode_led !== 4'b0001) begin
      errors++;
      $display("FAIL long_home: mode=%0d led=%b expected 0 0001", bus.mode, bus.mode_led);
    end
    tick(3);
    bus.mode_key = 1'b0;
    tick(10);
    checks++;
    if (bus.mode !== 2'd0) begin
      errors++;
      $display("FAIL long_release: mode=%0d expected 0", bus.mode);
    end
    short_press(0, 1);
  endtask

  // Starts 16 edges after the mode-key press that entered mode 1.
  task automatic test_timeout();
    tick(41);
    checks++;
    if (bus.mode !== 2'd1) begin
      errors++;
      $display("FAIL timeout_early: mode=%0d expected 1", bus.mode);
    end
    tick(1);
    checks++;
    if (bus.mode !== 2'd0 || bus.mode_led !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_home: mode=%0d led=%b expected 0 0001", bus.mode, bus.mode_led);
    end
    tick(1);
    checks++;
    if (bus.disp_data !== exp_digits(0)) begin
      errors++;
      $display("FAIL timeout_disp: data=%h expected %h", bus.disp_data, exp_digits(0));
    end
    tick(5);
    short_press(0, 1);
    tick(24);
    bus.keys_raw[1] = 1'b1;
    tick(6);
    checks++;
    if (bus.key_pulse !== '0) begin
      errors++;
      $display("FAIL fkey_early: key_pulse=%h expected 000", bus.key_pulse);
    end
    tick(1);
    checks++;
    if (bus.key_pulse !== 12'h010) begin
      errors++;
      $display("FAIL fkey_pulse: key_pulse=%h expected 010", bus.key_pulse);
    end
    tick(1);
    checks++;
    if (bus.key_pulse !== '0 || bus.key_held !== 12'h010) begin
      errors++;
      $display("FAIL fkey_held: pulse=%h held=%h expected 000 010", bus.key_pulse, bus.key_held);
    end
    tick(10);
    checks++;
    if (bus.mode !== 2'd1) begin
      errors++;
      $display("FAIL timeout_restart: mode=%0d expected 1", bus.mode);
    end
    tick(39);
    checks++;
    if (bus.mode !== 2'd1 || bus.key_held !== 12'h010) begin
      errors++;
      $display("FAIL timeout_b_early: mode=%0d held=%h expected 1 010", bus.mode, bus.key_held);
    end
    tick(1);
    checks++;
    if (bus.mode !== 2'd0 || bus.key_held !== '0) begin
      errors++;
      $display("FAIL timeout_b_home: mode=%0d held=%h expected 0 000", bus.mode, bus.key_held);
    end
    tick(1);
    checks++;
    if (bus.disp_data !== exp_digits(0) || bus.disp_blank !== exp_blank(0)) begin
      errors++;
      $display("FAIL timeout_b_disp: data=%h expected %h", bus.disp_data, exp_digits(0));
    end
    bus.keys_raw[1] = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_in_pressed();
    int bad = 0;
    short_press(0, 1);
    tick(5);
    short_press(1, 2);
    tick(5);
    short_press(2, 3);
    tick(5);
    bus.mode_key = 1'b1;
    tick(10);
    checks++;
    if (bus.mode !== 2'd3) begin
      errors++;
      $display("FAIL rst_pressed_pre: mode=%0d expected 3", bus.mode);
    end
    reset = 1'b1;
    tick(2);
    checks++;
    if (bus.mode !== 2'd0 || bus.mode_led !== 4'b0001 || bus.disp_data !== '0) begin
      errors++;
      $display("FAIL rst_pressed_reset: mode=%0d led=%b data=%h expected 0 0001 0",
               bus.mode, bus.mode_led, bus.disp_data);
    end
    reset = 1'b0;
    tick(1);
    bus.mode_key = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (bus.mode !== 2'd0 || bus.key_pulse !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_pressed_release: bad cycles=%0d expected 0 (mode=%0d)", bad, bus.mode);
    end
  endtask

  initial begin
    test_reset();
    test_key_debounce();
    test_mode_cycle();
    test_long_press();
    test_timeout();
    test_reset_in_pressed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
